// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : State encoding, opcode constants, ALU_INC and IR field positions
//            for control_sequencer. SEQ_MULDIV_EN adds state T6.
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
`ifdef SEQ_MULDIV_EN
        ST_T6     = 4'd7,
`endif
        ST_HALTED = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_RR      = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_NOP     = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHL  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_INC = 5'd12;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

endpackage
`default_nettype wire

// File: rtl/op_decode.sv
`default_nettype none
// ============================================================================
// Module   : op_decode
// Brief    : Maps a 5-bit opcode to its sequencing class. Macro SEQ_MULDIV_EN
//            enables the mul/div class; otherwise those opcodes are illegal.
// Revision : 1.0
// ============================================================================
module op_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: op_class = CLS_RR;
`ifdef SEQ_MULDIV_EN
            OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
`endif
            OP_NOP:                         op_class = CLS_NOP;
            OP_HALT:                        op_class = CLS_HALT;
            default:                        op_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Fetch/decode/execute control FSM with combinational strobes.
//            Macro SEQ_MULDIV_EN enables the mul/div T5/T6 sequence.
// Revision : 1.0
// ============================================================================
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  OpCode,
    output logic        Illegal
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_boundary;
    op_class_t  w_class;
    logic [4:0] w_opcode;
    logic       w_unused_fields;

    assign w_opcode = IR[OPC_MSB:OPC_LSB];
    // Register fields are steered by Gra/Grb/Grc in the datapath, not here.
    assign w_unused_fields = ^{IR[RA_MSB:RA_LSB], IR[RB_MSB:RB_LSB],
                               IR[RC_MSB:RC_LSB], IR[RC_LSB-1:0]};

    op_decode u_op_decode (
        .opcode   (w_opcode),
        .op_class (w_class)
    );

    // Stop is honoured only at instruction boundaries (entry to T0).
    assign w_boundary = Stop ? ST_HALTED : ST_T0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= ST_RST;
        else     r_state <= w_next;
    end

`ifdef SEQ_MULDIV_EN
    logic w_lo_in;
    logic w_hi_in;
    assign LOin = w_lo_in;
    assign HIin = w_hi_in;
`else
    assign LOin = 1'b0;
    assign HIin = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        Run      = 1'b0;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        OpCode   = 5'd0;
        Illegal  = 1'b0;
`ifdef SEQ_MULDIV_EN
        w_lo_in  = 1'b0;
        w_hi_in  = 1'b0;
`endif
        case (r_state)
            ST_RST: w_next = w_boundary;
            ST_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
                OpCode = ALU_INC;
                w_next = ST_T1;
            end
            ST_T1: begin
                Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                w_next = ST_T2;
            end
            ST_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                case (w_class)
                    CLS_NOP:     w_next = w_boundary;
                    CLS_HALT:    w_next = ST_HALTED;
                    CLS_ILLEGAL: begin
                        Illegal = 1'b1;
                        w_next  = w_boundary;
                    end
                    default:     w_next = ST_T3;
                endcase
            end
            ST_T3: begin
                Run = 1'b1; Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                w_next = ST_T4;
            end
            ST_T4: begin
                Run = 1'b1; Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                OpCode = w_opcode;
                w_next = ST_T5;
            end
            ST_T5: begin
                Run = 1'b1; Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (w_class == CLS_MULDIV) begin
                    w_lo_in = 1'b1;
                    w_next  = ST_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    w_next = w_boundary;
                end
`else
                Gra = 1'b1; Rin = 1'b1;
                w_next = w_boundary;
`endif
            end
`ifdef SEQ_MULDIV_EN
            ST_T6: begin
                Run = 1'b1; Zhighout = 1'b1; w_hi_in = 1'b1;
                w_next = w_boundary;
            end
`endif
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_RST;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Directed self-checking bench for control_sequencer; follows
//            SEQ_MULDIV_EN to choose the mul/div expectations.
// Revision : 1.0
// ============================================================================
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        Stop;
    logic        Run, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
    logic        IRin, Yin, LOin, HIin, Read, Gra, Grb, Grc, Rin, Rout, Illegal;
    logic [4:0]  OpCode;

    int n_checks;
    int n_fail;

    control_sequencer u_dut (
        .clk      (clk),
        .clr      (clr),
        .IR       (IR),
        .Stop     (Stop),
        .Run      (Run),
        .PCout    (PCout),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .MDRout   (MDRout),
        .MARin    (MARin),
        .Zin      (Zin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .LOin     (LOin),
        .HIin     (HIin),
        .Read     (Read),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .OpCode   (OpCode),
        .Illegal  (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bit positions in the observed vector (above the 5-bit OpCode).
    localparam logic [19:0] B_RUN  = 20'd1 << 19;
    localparam logic [19:0] B_PCO  = 20'd1 << 18;
    localparam logic [19:0] B_ZLO  = 20'd1 << 17;
    localparam logic [19:0] B_ZHO  = 20'd1 << 16;
    localparam logic [19:0] B_MDRO = 20'd1 << 15;
    localparam logic [19:0] B_MARI = 20'd1 << 14;
    localparam logic [19:0] B_ZIN  = 20'd1 << 13;
    localparam logic [19:0] B_PCI  = 20'd1 << 12;
    localparam logic [19:0] B_MDRI = 20'd1 << 11;
    localparam logic [19:0] B_IRI  = 20'd1 << 10;
    localparam logic [19:0] B_YIN  = 20'd1 << 9;
    localparam logic [19:0] B_LOI  = 20'd1 << 8;
    localparam logic [19:0] B_HII  = 20'd1 << 7;
    localparam logic [19:0] B_RD   = 20'd1 << 6;
    localparam logic [19:0] B_GRA  = 20'd1 << 5;
    localparam logic [19:0] B_GRB  = 20'd1 << 4;
    localparam logic [19:0] B_GRC  = 20'd1 << 3;
    localparam logic [19:0] B_RIN  = 20'd1 << 2;
    localparam logic [19:0] B_ROUT = 20'd1 << 1;
    localparam logic [19:0] B_ILL  = 20'd1 << 0;

    localparam logic [24:0] E_IDLE = 25'd0;
    localparam logic [24:0] E_T0   = {B_RUN | B_PCO | B_MARI | B_ZIN, 5'd12};
    localparam logic [24:0] E_T1   = {B_RUN | B_ZLO | B_PCI | B_RD | B_MDRI, 5'd0};
    localparam logic [24:0] E_T2   = {B_RUN | B_MDRO | B_IRI, 5'd0};
    localparam logic [24:0] E_T2IL = {B_RUN | B_MDRO | B_IRI | B_ILL, 5'd0};
    localparam logic [24:0] E_T3   = {B_RUN | B_GRB | B_ROUT | B_YIN, 5'd0};
    localparam logic [24:0] E_T5RR = {B_RUN | B_ZLO | B_GRA | B_RIN, 5'd0};
    localparam logic [24:0] E_T5MD = {B_RUN | B_ZLO | B_LOI, 5'd0};
    localparam logic [24:0] E_T6   = {B_RUN | B_ZHO | B_HII, 5'd0};

    function automatic logic [24:0] e_t4(input logic [4:0] op);
        return {B_RUN | B_GRC | B_ROUT | B_ZIN, op};
    endfunction

    logic [24:0] w_obs;
    assign w_obs = {Run, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
                    IRin, Yin, LOin, HIin, Read, Gra, Grb, Grc, Rin, Rout, Illegal,
                    OpCode};

    task automatic chk(input string tag, input logic [24:0] exp);
        n_checks++;
        assert (w_obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [24:0] exp);
        @(posedge clk);
        @(negedge clk);
        chk(tag, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr  = 1'b1;
        Stop = 1'b0;
        IR   = 32'h3B32_0000;
        repeat (2) @(negedge clk);
        chk("reset_state", E_IDLE);
        clr = 1'b0;

        // ror R6,R6,R4
        step("ror_t0", E_T0);
        step("ror_t1", E_T1);
        step("ror_t2", E_T2);
        step("ror_t3", E_T3);
        step("ror_t4", e_t4(5'd7));
        step("ror_t5", E_T5RR);
        step("ror_back_t0", E_T0);

        // and R1,R2,R3
        IR = 32'h2891_8000;
        step("and_t1", E_T1);
        step("and_t2", E_T2);
        step("and_t3", E_T3);
        step("and_t4", e_t4(5'd5));
        step("and_t5", E_T5RR);
        step("and_t0", E_T0);

        // nop returns from T2 straight to T0
        IR = 32'hD000_0000;
        step("nop_t1", E_T1);
        step("nop_t2", E_T2);
        step("nop_t0", E_T0);

        // halt is absorbing
        IR = 32'hD800_0000;
        step("halt_t1", E_T1);
        step("halt_t2", E_T2);
        step("halted", E_IDLE);
        for (int i = 0; i < 10; i++) step("halted_stay", E_IDLE);

        clr = 1'b1;
        #1 chk("clr_from_halted", E_IDLE);
        @(negedge clk);
        clr = 1'b0;
        step("restart_t0", E_T0);

        // mul
        IR = 32'h7800_0000;
        step("mul_t1", E_T1);
`ifdef SEQ_MULDIV_EN
        step("mul_t2", E_T2);
        step("mul_t3", E_T3);
        step("mul_t4", e_t4(5'd15));
        step("mul_t5_lo", E_T5MD);
        step("mul_t6_hi", E_T6);
        step("mul_t0", E_T0);
`else
        step("mul_t2_illegal", E_T2IL);
        step("mul_illegal_t0", E_T0);
`endif

        // Stop raised in T3 lets the instruction finish, then halts
        IR = 32'h3B32_0000;
        step("stop_t1", E_T1);
        step("stop_t2", E_T2);
        step("stop_t3", E_T3);
        Stop = 1'b1;
        step("stop_t4", e_t4(5'd7));
        step("stop_t5", E_T5RR);
        step("stop_halted", E_IDLE);
        Stop = 1'b0;
        step("stop_halted_stay", E_IDLE);

        // clr mid-T4 aborts immediately
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        step("abort_t0", E_T0);
        step("abort_t1", E_T1);
        step("abort_t2", E_T2);
        step("abort_t3", E_T3);
        step("abort_t4", e_t4(5'd7));
        clr = 1'b1;
        #1 chk("abort_clr_now", E_IDLE);
        @(negedge clk);
        chk("abort_held", E_IDLE);
        clr = 1'b0;
        step("abort_release_t0", E_T0);

        // Stop during RST goes directly to HALTED
        clr  = 1'b1;
        Stop = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        step("rst_stop_halted", E_IDLE);
        Stop = 1'b0;
        step("rst_stop_stay", E_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, required end within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and clr (asynchronous, active-high).
REQ-002 The ports SHALL be, with name, direction, width and meaning:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- IR  in  32  instruction register contents from the datapath.
- Stop  in  1  request to halt at the next instruction boundary.
- Run  out  1  high while sequencing; low when halted or in reset.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus-drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin  out  1 each  register loads.
- Read  out  1  memory read strobe.
- Gra, Grb, Grc  out  1 each  select register field ra/rb/rc.
- Rin, Rout  out  1 each  load/drive the selected general register.
- OpCode  out  5  ALU operation code.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-003 Instruction fields SHALL be: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-004 Supported opcodes SHALL be: add 3, sub 4, and 5, or 6, ror 7, rol 8, shr 9, shl 10, mul 15, div 16, nop 26, halt 27.
REQ-005 The states SHALL be RST, T0, T1, T2, T3, T4, T5, T6 and HALTED, with one state per clk cycle.
REQ-006 Outputs SHALL be combinational from the state and IR, and every output not listed for a state SHALL be 0.
REQ-007 T0 SHALL assert PCout, MARin and Zin, with OpCode = ALU_INC (12).
REQ-008 T1 SHALL assert Zlowout, PCin, Read and MDRin.
REQ-009 T2 SHALL assert MDRout and IRin.
REQ-010 T2 SHALL transition as follows:
- nop: to T0.
- halt: to HALTED.
- unsupported opcode: to T0, with Illegal high during T2.
- any other opcode: to T3.
REQ-011 T3 SHALL assert Grb, Rout and Yin.
REQ-012 T4 SHALL assert Grc, Rout and Zin, with OpCode = IR[31:27].
REQ-013 T5 for a register-register operation SHALL assert Zlowout, Gra and Rin, then go to T0.
REQ-014 T5 for mul/div SHALL assert Zlowout and LOin, then go to T6.
REQ-015 T6 SHALL assert Zhighout and HIin, then go to T0.
REQ-016 The transition into T0 SHALL go to HALTED instead when Stop is sampled high on that edge; a Stop asserted mid-instruction SHALL never truncate the instruction.
REQ-017 HALTED SHALL be absorbing: all strobes 0, Run = 0, exited only by clr.
REQ-018 Run SHALL be 1 in T0 through T6 and 0 in RST and HALTED.

Reset
REQ-019 clr high SHALL immediately force RST with every output 0, including Run and Illegal, aborting any in-progress instruction.
REQ-020 The first rising clk edge with clr low SHALL move the block from RST to T0.
REQ-021 Stop high during RST SHALL cause the block to go from RST to HALTED.

Configuration
REQ-022 Multiply/divide support SHALL be controlled by the macro SEQ_MULDIV_EN:
- Defined: mul and div are sequenced as in REQ-014 and REQ-015.
- Undefined: opcodes 15 and 16 are treated as unsupported (Illegal pulse, return to T0), and state T6 and the LOin/HIin logic SHALL be absent, with both ports tied to 0.

Structure
REQ-023 Package ctrl_pkg SHALL hold the state encoding, the opcode constants, ALU_INC and the IR field bit positions.
REQ-024 One sub-module, op_decode, SHALL map the opcode to the class {RR, MULDIV, NOP, HALT, ILLEGAL}; all other logic is in control_sequencer.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Release clr, apply IR=0x3B320000 (ror R6,R6,R4) -> T0..T5 in 6 cycles; OpCode 12 in T0, 7 in T4; Gra+Rin in T5; then back to T0.
- Apply IR=0x28918000 (and R1,R2,R3) -> OpCode 5 in T4; Grb+Rout in T3; Grc+Rout in T4.
- Apply IR=0xD0000000 (nop) -> T2 to T0 with no Yin/Zin in T3/T4; apply IR=0xD8000000 (halt) -> HALTED, Run=0, stays halted for 10 cycles.
- Apply IR=0x78000000 (mul) with SEQ_MULDIV_EN defined -> LOin in T5, HIin in T6; without the macro -> Illegal=1 for 1 cycle, no LOin/HIin.
- Assert Stop during T3 -> T4, T5 complete, then HALTED instead of T0; assert clr mid-T4 -> outputs 0 immediately, T0 one cycle after release.
